// File: rtl/clock_display_pkg.sv
// Shared constants and helpers for the six-digit HH:MM:SS multiplexed display.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package clock_display_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] DASH  = 7'h3F;
   localparam logic [6:0] BLANK = 7'h7F;

   // Digit code driven into seg7_decode when a field is out of range.
   localparam logic [3:0] DIGIT_DASH = 4'hA;

   // Indexed by decimal digit; entry 0 is the rightmost element.
   localparam logic [9:0][6:0] SEG_CODE = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                           7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] minute;
      logic [5:0] sec;
   } time_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } digits_t;

   // Tens/ones split by range comparison; inputs never exceed 63.
   function automatic digits_t split_dec(input logic [5:0] v);
      digits_t d;
      if (v >= 6'd60) begin
         d.tens = 4'd6; d.ones = 4'(v - 6'd60);
      end else if (v >= 6'd50) begin
         d.tens = 4'd5; d.ones = 4'(v - 6'd50);
      end else if (v >= 6'd40) begin
         d.tens = 4'd4; d.ones = 4'(v - 6'd40);
      end else if (v >= 6'd30) begin
         d.tens = 4'd3; d.ones = 4'(v - 6'd30);
      end else if (v >= 6'd20) begin
         d.tens = 4'd2; d.ones = 4'(v - 6'd20);
      end else if (v >= 6'd10) begin
         d.tens = 4'd1; d.ones = 4'(v - 6'd10);
      end else begin
         d.tens = 4'd0; d.ones = v[3:0];
      end
      return d;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decimal digit to active-low seven-segment code; 10..15 give a dash.
// Zero latency, no flow control.
module seg7_decode
   import clock_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = DASH;
      if (digit <= 4'd9) seg = SEG_CODE[digit];
   end

endmodule

// File: rtl/clock_display_mux.sv
// Time-multiplexed HH:MM:SS driver: one digit per REFRESH_DIV clocks, frame-atomic input snapshot.
// an/seg/dp are registered (1 clk after index/snapshot state); no backpressure.
module clock_display_mux
   import clock_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] sec,
   input  logic [5:0] minute,
   input  logic [4:0] hour,
   input  logic       blank_lead,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int PW = $clog2(REFRESH_DIV);

   logic [PW-1:0] psc;
   logic [2:0]    idx;
   time_t         snap;
   logic          tick;
   digits_t       s_d, m_d, h_d;
   logic          s_ok, m_ok, h_ok;
   logic [3:0]    cur_digit;
   logic [6:0]    cur_seg;
   logic          blank_now;
   logic [5:0]    an_nxt;
   logic          dp_nxt;

   assign tick        = (psc == PW'(REFRESH_DIV - 1));
   assign frame_start = !rst && (idx == 3'd0) && (psc == '0);

   assign s_d  = split_dec(snap.sec);
   assign m_d  = split_dec(snap.minute);
   assign h_d  = split_dec({1'b0, snap.hour});
   assign s_ok = (snap.sec <= 6'd59);
   assign m_ok = (snap.minute <= 6'd59);
   assign h_ok = (snap.hour <= 5'd23);

   always_comb begin
      cur_digit = DIGIT_DASH;
      case (idx)
         3'd0: cur_digit = s_ok ? s_d.ones : DIGIT_DASH;
         3'd1: cur_digit = s_ok ? s_d.tens : DIGIT_DASH;
         3'd2: cur_digit = m_ok ? m_d.ones : DIGIT_DASH;
         3'd3: cur_digit = m_ok ? m_d.tens : DIGIT_DASH;
         3'd4: cur_digit = h_ok ? h_d.ones : DIGIT_DASH;
         3'd5: cur_digit = h_ok ? h_d.tens : DIGIT_DASH;
         default: cur_digit = DIGIT_DASH;
      endcase
   end

   seg7_decode u_dec (
      .digit (cur_digit),
      .seg   (cur_seg)
   );

   // A dashed hour never counts as a leading zero.
   assign blank_now = (idx == 3'd5) && blank_lead && h_ok && (h_d.tens == 4'd0);
   assign an_nxt    = blank_now ? '1 : ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
   assign dp_nxt    = !(((idx == 3'd2) || (idx == 3'd4)) && !snap.sec[0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         psc  <= '0;
         idx  <= '0;
         snap <= '0;
         an   <= '1;
         seg  <= BLANK;
         dp   <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= cur_seg;
         dp  <= dp_nxt;
         if (tick) begin
            psc <= '0;
            if (idx == 3'(NUM_DIGITS - 1)) begin
               idx  <= '0;
               snap <= '{hour: hour, minute: minute, sec: sec};
            end else begin
               idx <= idx + 3'd1;
            end
         end else begin
            psc <= psc + PW'(1);
         end
      end
   end

endmodule
